// File: rtl/lc3_dmem_responder.sv
// LC-3 data-memory responder: one outstanding access, LATENCY-cycle service, word array backing store.
// Optional out-of-range error flag enabled by defining LC3_DMEM_ERR_EN.
`timescale 1ns/1ps
module lc3_dmem_responder #(
   parameter logic [15:0] ADDR_BASE  = 16'h3000,
   parameter int          DEPTH      = 256,
   parameter int          LATENCY    = 2,
   parameter logic [15:0] INIT_VALUE = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Data_en,
   input  logic        Data_rd,
   input  logic [15:0] Data_addr,
   input  logic [15:0] Data_din,
   output logic [15:0] Data_dout,
   output logic        complete_data,
   output logic        busy,
   output logic        Data_err
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [15:0]    addr_q, addr_d;
   logic [15:0]    din_q, din_d;
   logic           rd_q, rd_d;
   logic [15:0]    mem_q [DEPTH];
   logic [15:0]    dout_q;
   logic           done_q;
   logic           busy_q;

   logic           accept_s;
   logic           enter_resp_s;
   logic [15:0]    cur_addr_s;
   logic [15:0]    cur_din_s;
   logic           cur_rd_s;
   logic [15:0]    cur_off_s;
   logic           cur_in_s;
   logic [AW-1:0]  cur_idx_s;

   function automatic logic in_range_f(input logic [15:0] off);
      return ({1'b0, off} < 17'(DEPTH));
   endfunction

   assign accept_s     = Data_en && (state_q != WAIT);
   assign enter_resp_s = (state_d == RESP);

   // With LATENCY=1 the access completes on its accept edge, so it must use the live request.
   assign cur_addr_s = (state_q == WAIT) ? addr_q : Data_addr;
   assign cur_din_s  = (state_q == WAIT) ? din_q  : Data_din;
   assign cur_rd_s   = (state_q == WAIT) ? rd_q   : Data_rd;
   assign cur_off_s  = cur_addr_s - ADDR_BASE;
   assign cur_in_s   = in_range_f(cur_off_s);
   assign cur_idx_s  = cur_off_s[AW-1:0];

   // Next-state, latency counter and request latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rd_d    = rd_q;
      case (state_q)
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         IDLE, RESP: begin
            if (accept_s) begin
               addr_d  = Data_addr;
               din_d   = Data_din;
               rd_d    = Data_rd;
               cnt_d   = LAT_LOAD;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'h0000;
         din_q   <= 16'h0000;
         rd_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         rd_q    <= rd_d;
         done_q  <= enter_resp_s;
         busy_q  <= (state_d == WAIT);
      end
   end

   // Backing array and read data; both act only on the edge that enters RESP.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INIT_VALUE;
         end
         dout_q <= 16'h0000;
      end else if (enter_resp_s) begin
         if (cur_rd_s) begin
            dout_q <= cur_in_s ? mem_q[cur_idx_s] : 16'h0000;
         end else if (cur_in_s) begin
            mem_q[cur_idx_s] <= cur_din_s;
         end
      end
   end

`ifdef LC3_DMEM_ERR_EN
   logic err_q;

   // Out-of-range flag, registered alongside the completion pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= enter_resp_s && !cur_in_s;
      end
   end

   assign Data_err = err_q;
`else
   assign Data_err = 1'b0;
`endif

   assign Data_dout     = dout_q;
   assign complete_data = done_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Directed self-checking bench: four responders with LATENCY 1..4 share clock, reset and request buses.
`timescale 1ns/1ps
module tb_lc3_dmem_responder;

`ifdef LC3_DMEM_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic [3:0]  en_s;
   logic        rd_s;
   logic [15:0] addr_s;
   logic [15:0] din_s;
   logic [15:0] dout_s [4];
   logic [3:0]  cd_s;
   logic [3:0]  busy_s;
   logic [3:0]  err_s;

   int checks;
   int errors;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      lc3_dmem_responder #(
         .ADDR_BASE (16'h3000),
         .DEPTH     (256),
         .LATENCY   (g + 1),
         .INIT_VALUE(16'h0000)
      ) u_dut (
         .clock        (clock),
         .reset        (reset),
         .Data_en      (en_s[g]),
         .Data_rd      (rd_s),
         .Data_addr    (addr_s),
         .Data_din     (din_s),
         .Data_dout    (dout_s[g]),
         .complete_data(cd_s[g]),
         .busy         (busy_s[g]),
         .Data_err     (err_s[g])
      );
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One isolated access on responder k (LATENCY k+1), checking every cycle up to the pulse.
   task automatic do_access(input int k, input logic rd, input logic [15:0] addr,
                            input logic [15:0] din, input logic [15:0] exp_dout,
                            input logic exp_err);
      en_s[k] = 1'b1;
      rd_s    = rd;
      addr_s  = addr;
      din_s   = din;
      tick();
      en_s[k] = 1'b0;
      for (int i = 0; i < k; i++) begin
         check_eq("wait_cd", {15'd0, cd_s[k]}, 16'd0);
         check_eq("wait_busy", {15'd0, busy_s[k]}, 16'd1);
         tick();
      end
      check_eq("resp_cd", {15'd0, cd_s[k]}, 16'd1);
      check_eq("resp_busy", {15'd0, busy_s[k]}, 16'd0);
      check_eq("resp_dout", dout_s[k], exp_dout);
      check_eq("resp_err", {15'd0, err_s[k]}, {15'd0, exp_err});
      tick();
      check_eq("post_cd", {15'd0, cd_s[k]}, 16'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      en_s   = 4'b0000;
      rd_s   = 1'b0;
      addr_s = 16'h0000;
      din_s  = 16'h0000;

      repeat (3) tick();
      check_eq("rst_dout", dout_s[1], 16'h0000);
      check_eq("rst_cd", {12'd0, cd_s}, 16'd0);
      check_eq("rst_busy", {12'd0, busy_s}, 16'd0);
      check_eq("rst_err", {12'd0, err_s}, 16'd0);
      reset = 1'b1;

      // First accept on the first edge after reset release.
      do_access(1, 1'b1, 16'h3005, 16'h0000, 16'h0000, 1'b0);

      // Write then read accepted in the write's RESP cycle.
      en_s[1] = 1'b1; rd_s = 1'b0; addr_s = 16'h3010; din_s = 16'hBEEF;
      tick();
      en_s[1] = 1'b0;
      check_eq("wr_busy", {15'd0, busy_s[1]}, 16'd1);
      tick();
      check_eq("wr_cd", {15'd0, cd_s[1]}, 16'd1);
      check_eq("wr_dout_hold", dout_s[1], 16'h0000);
      en_s[1] = 1'b1; rd_s = 1'b1; addr_s = 16'h3010; din_s = 16'h0000;
      tick();
      en_s[1] = 1'b0;
      check_eq("rb_cd_gap", {15'd0, cd_s[1]}, 16'd0);
      check_eq("rb_busy", {15'd0, busy_s[1]}, 16'd1);
      tick();
      check_eq("rb_cd", {15'd0, cd_s[1]}, 16'd1);
      check_eq("rb_dout", dout_s[1], 16'hBEEF);
      tick();
      check_eq("rb_post_cd", {15'd0, cd_s[1]}, 16'd0);

      // Top-of-array boundary, neighbour untouched, out-of-range accesses.
      do_access(1, 1'b0, 16'h30FF, 16'hA5A5, 16'hBEEF, 1'b0);
      do_access(1, 1'b1, 16'h30FF, 16'h0000, 16'hA5A5, 1'b0);
      do_access(1, 1'b1, 16'h3011, 16'h0000, 16'h0000, 1'b0);
      do_access(1, 1'b1, 16'h30FF, 16'h0000, 16'hA5A5, 1'b0);
      do_access(1, 1'b1, 16'h2FFF, 16'h0000, 16'h0000, ERR_ON);
      do_access(1, 1'b0, 16'h3100, 16'h1111, 16'h0000, ERR_ON);
      do_access(1, 1'b1, 16'h3000, 16'h0000, 16'h0000, 1'b0);
      do_access(1, 1'b1, 16'h3010, 16'h0000, 16'hBEEF, 1'b0);

      // LATENCY=3: Data_en held high, strobes during WAIT must be ignored.
      do_access(2, 1'b0, 16'h3001, 16'h1111, 16'h0000, 1'b0);
      do_access(2, 1'b0, 16'h3002, 16'h2222, 16'h0000, 1'b0);
      en_s[2] = 1'b1; rd_s = 1'b1; addr_s = 16'h3001;
      tick();
      addr_s = 16'h3002;
      check_eq("hold_c1", {15'd0, cd_s[2]}, 16'd0);
      tick();
      check_eq("hold_c2", {15'd0, cd_s[2]}, 16'd0);
      check_eq("hold_busy2", {15'd0, busy_s[2]}, 16'd1);
      tick();
      check_eq("hold_c3", {15'd0, cd_s[2]}, 16'd1);
      check_eq("hold_d3", dout_s[2], 16'h1111);
      tick();
      en_s[2] = 1'b0;
      check_eq("hold_c4", {15'd0, cd_s[2]}, 16'd0);
      tick();
      check_eq("hold_c5", {15'd0, cd_s[2]}, 16'd0);
      tick();
      check_eq("hold_c6", {15'd0, cd_s[2]}, 16'd1);
      check_eq("hold_d6", dout_s[2], 16'h2222);
      tick();
      check_eq("hold_c7", {15'd0, cd_s[2]}, 16'd0);

      // LATENCY=1 streaming: four reads, four consecutive pulses, busy never high.
      for (int i = 0; i < 4; i++) begin
         do_access(0, 1'b0, 16'h3000 + 16'(i), 16'hA000 + 16'(i), 16'h0000, 1'b0);
      end
      en_s[0] = 1'b1; rd_s = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr_s = 16'h3000 + 16'(i);
         tick();
         check_eq("strm_cd", {15'd0, cd_s[0]}, 16'd1);
         check_eq("strm_dout", dout_s[0], 16'hA000 + 16'(i));
         check_eq("strm_busy", {15'd0, busy_s[0]}, 16'd0);
      end
      en_s[0] = 1'b0;
      tick();
      check_eq("strm_end_cd", {15'd0, cd_s[0]}, 16'd0);

      // LATENCY=4: reset during a pending write aborts it.
      en_s[3] = 1'b1; rd_s = 1'b0; addr_s = 16'h3020; din_s = 16'h1234;
      tick();
      en_s[3] = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check_eq("abort_busy", {15'd0, busy_s[3]}, 16'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("abort_cd", {15'd0, cd_s[3]}, 16'd0);
      end
      reset = 1'b1;
      do_access(3, 1'b1, 16'h3020, 16'h0000, 16'h0000, 1'b0);
      do_access(1, 1'b1, 16'h3010, 16'h0000, 16'h0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
